// File: rtl/wave_display_pkg.sv
// Shared types and constants for the multi-channel waveform renderer.
package wave_display_pkg;

  localparam int DEF_SAMPLE_W = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Channel 0 occupies the low 24 bits.
  localparam logic [47:0] DEF_CH_COLOR = {24'hFFFFFF, 24'h00FF00};

  localparam rgb_t       GRID_GREY    = 24'h404040;
  localparam int         GRID_X_PITCH = 64;
  localparam logic [4:0] GRID_Y_MASK  = 5'h1F;

endpackage

// File: rtl/wave_span_tracker.sv
// Per-channel sample scaling, previous/current span pair and row hit test.
module wave_span_tracker
  import wave_display_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int AMP_SHIFT = 1,
  parameter int Y_OFFSET  = 32
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                in_win_i,
  input  logic                first_i,
  input  logic                load_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [7:0]          y8_i,
  output logic                hit_o
);

  localparam int CW = (SAMPLE_W > 8) ? SAMPLE_W : 8;

  // Shift down, add the vertical offset one bit wider, clip at full scale.
  function automatic logic [SAMPLE_W-1:0] scale_sat(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W:0] sum;
    sum = {1'b0, (s >> AMP_SHIFT)} + (SAMPLE_W+1)'(Y_OFFSET);
    return sum[SAMPLE_W] ? {SAMPLE_W{1'b1}} : sum[SAMPLE_W-1:0];
  endfunction

  logic [SAMPLE_W-1:0] adj;
  logic [SAMPLE_W-1:0] prev_q;
  logic [SAMPLE_W-1:0] curr_q;
  logic [SAMPLE_W-1:0] lo;
  logic [SAMPLE_W-1:0] hi;

  assign adj = scale_sat(sample_i);

  // Span pair: seeded flat on the first column of a line, shifted on each new address.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      prev_q <= '0;
      curr_q <= '0;
    end else if (first_i) begin
      prev_q <= adj;
      curr_q <= adj;
    end else if (load_i) begin
      prev_q <= curr_q;
      curr_q <= adj;
    end
  end

  assign lo    = (prev_q < curr_q) ? prev_q : curr_q;
  assign hi    = (prev_q < curr_q) ? curr_q : prev_q;
  assign hit_o = in_win_i && (CW'(y8_i) >= CW'(lo)) && (CW'(y8_i) <= CW'(hi));

endmodule

// File: rtl/wave_display_mc.sv
// Multi-channel waveform renderer with one cycle of output latency.
// Optional background grid is built when WAVE_DISPLAY_GRID_EN is defined.
module wave_display_mc
  import wave_display_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int ADDR_W    = 9,
  parameter int X_START   = 260,
  parameter int X_END     = 1023,
  parameter int PIX_SHIFT = 1,
  parameter int AMP_SHIFT = 1,
  parameter int Y_OFFSET  = 32,
  parameter logic [NUM_CH*24-1:0] CH_COLOR = (NUM_CH*24)'(DEF_CH_COLOR)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                x,
  input  logic [9:0]                 y,
  input  logic                       valid,
  input  logic                       read_index,
  input  logic [NUM_CH*SAMPLE_W-1:0] read_value,
  output logic [ADDR_W-1:0]          read_address,
  output logic                       valid_pixel,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b
);

  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
    $error("wave_display_mc: NUM_CH must be in 1..4");
  end
  if (X_START < 0 || X_START > X_END || X_END > 1279) begin : g_bad_window
    $error("wave_display_mc: X window must satisfy 0 <= X_START <= X_END <= 1279");
  end
  if (ADDR_W < 2 || ADDR_W > 32) begin : g_bad_addr_w
    $error("wave_display_mc: ADDR_W must be in 2..32");
  end

  localparam logic [10:0] XS = 11'(X_START);
  localparam logic [10:0] XE = 11'(X_END);

  logic              in_win;
  logic              in_win_q;
  logic              first;
  logic              load;
  logic [10:0]       x_rel;
  logic [31:0]       x_sh;
  logic [ADDR_W-1:0] ra_last_q;
  logic [NUM_CH-1:0] hit;
  logic              grid_on;
  rgb_t              rgb_d;
  rgb_t              rgb_q;
  logic              vp_d;
  logic              vp_q;
  logic              unused_ok;

  assign in_win = valid & ~y[9] & (x >= XS) & (x <= XE);

  // Outside the window the column collapses to the one for X_START.
  assign x_rel        = in_win ? (x - XS) : 11'd0;
  assign x_sh         = {21'd0, x_rel} >> PIX_SHIFT;
  assign read_address = {read_index, x_sh[ADDR_W-2:0]};

  assign first = in_win & ~in_win_q;
  assign load  = in_win & (read_address != ra_last_q);

  // Remember the last in-window address and whether the previous pixel was in the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra_last_q <= '0;
      in_win_q  <= 1'b0;
    end else begin
      in_win_q <= in_win;
      if (in_win) begin
        ra_last_q <= read_address;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wave_span_tracker #(
      .SAMPLE_W  (SAMPLE_W),
      .AMP_SHIFT (AMP_SHIFT),
      .Y_OFFSET  (Y_OFFSET)
    ) u_trk (
      .clk      (clk),
      .reset_i  (reset),
      .in_win_i (in_win),
      .first_i  (first),
      .load_i   (load),
      .sample_i (read_value[c*SAMPLE_W +: SAMPLE_W]),
      .y8_i     (y[8:1]),
      .hit_o    (hit[c])
    );
  end

`ifdef WAVE_DISPLAY_GRID_EN
  assign grid_on = in_win &
                   (((x_rel & 11'(GRID_X_PITCH - 1)) == 11'd0) |
                    ((y[4:0] & GRID_Y_MASK) == 5'd0));
`else
  assign grid_on = 1'b0;
`endif

  // Colour select: grid underneath, then channels with the lowest index on top.
  always_comb begin
    rgb_d = '0;
    vp_d  = 1'b0;
    if (grid_on) begin
      rgb_d = GRID_GREY;
      vp_d  = 1'b1;
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit[c]) begin
        rgb_d = rgb_t'(CH_COLOR[c*24 +: 24]);
        vp_d  = 1'b1;
      end
    end
  end

  // Registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
      vp_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      vp_q  <= vp_d;
    end
  end

  assign r           = rgb_q.r;
  assign g           = rgb_q.g;
  assign b           = rgb_q.b;
  assign valid_pixel = vp_q;

  assign unused_ok = ^{y[0], x_sh[31:ADDR_W-1]};

endmodule
